hazard_scoreboard: RTL

Parametrised successor to the pipeline hazard unit. It tracks in-flight register writes across DEPTH post-decode stages in a shift-register scoreboard. Each cycle it decides, per decode-stage source operand, whether to stall or which stage to forward from. It also squashes the fetched instruction on a taken branch or jump, and counts stall cycles for performance reporting. It sits beside the decode stage and drives the IF/ID enable, ID/EX bubble insertion and the decode-stage forwarding muxes.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_match.sv | 32 +++
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and its match helper.
package hazard_pkg;

    // Width of the register index held in a scoreboard entry. Narrower
    // register indices are zero-extended into it, so REG_W must not exceed it.
    localparam int SB_REG_W = 8;

    // Forward-select value meaning "read the register file".
    localparam int FWD_RF = 0;

    // Default first stage index at which a result can be forwarded.
    localparam int ALU_STAGE_D  = 1;
    localparam int LOAD_STAGE_D = 2;

    // One in-flight register write, tracked per post-decode stage.
    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] wreg;
        logic                is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority search of one source operand against the scoreboard.
// Stage 0 is the youngest entry; the lowest matching stage index wins.
module hazard_match #(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int K_W   = $clog2(DEPTH + 1)
) (
    input  logic                        use_i,
    input  logic [REG_W-1:0]            src_i,
    input  logic [DEPTH-1:0]            sb_valid_i,
    input  logic [DEPTH-1:0][REG_W-1:0] sb_wreg_i,
    input  logic [DEPTH-1:0]            sb_load_i,
    output logic                        hit_o,
    output logic [K_W-1:0]              k_o,
    output logic                        is_load_o
);

    // Scan oldest to youngest so that a younger match overrides an older one.
    always_comb begin
        hit_o     = 1'b0;
        k_o       = '0;
        is_load_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_i && (src_i != '0) && sb_valid_i[k] && (sb_wreg_i[k] == src_i)) begin
                hit_o     = 1'b1;
                k_o       = K_W'(k);
                is_load_o = sb_load_i[k];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register writes over DEPTH
// post-decode stages and, per decode-stage operand, decides stall or forward.
// Also squashes IF/ID on a taken branch/jump and counts stall cycles.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the decode
// instruction; stall tells the pipeline to hold PC and IF/ID and to bubble
// ID/EX in the same cycle; freeze holds every register in this block.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_STAGE  = ALU_STAGE_D,
    parameter int LOAD_STAGE = LOAD_STAGE_D,
    parameter int FORWARD    = 1,
    parameter int CNT_W      = 32,
    parameter int FWD_W      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_use,
    input  logic             id_rt_use,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             freeze,
    output logic             stall,
    output logic             flush,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [FWD_W-1:0] ALU_K  = FWD_W'(ALU_STAGE);
    localparam logic [FWD_W-1:0] LOAD_K = FWD_W'(LOAD_STAGE);
    localparam logic [FWD_W-1:0] RF_K   = FWD_W'(FWD_RF);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DEPTH-1:0]               sb_valid;
    logic [DEPTH-1:0]               sb_load;
    logic [DEPTH-1:0][SB_REG_W-1:0] sb_wreg;

    logic             hit_a, hit_b;
    logic             load_a, load_b;
    logic [FWD_W-1:0] k_a, k_b;
    logic             stall_a, stall_b;
    logic             stall_int;

    // A match is a hazard when forwarding is off or the producer's result is
    // not yet available at the stage it currently occupies.
    function automatic logic needs_stall(input logic hit, input logic ld,
                                         input logic [FWD_W-1:0] k);
        if (!hit) begin
            return 1'b0;
        end
        if (FORWARD == 0) begin
            return 1'b1;
        end
        return ld ? (k < LOAD_K) : (k < ALU_K);
    endfunction

    // Flatten the entry array into the packed vectors the match search reads.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sb_valid[k] = sb_q[k].valid;
            sb_wreg[k]  = sb_q[k].wreg;
            sb_load[k]  = sb_q[k].is_load;
        end
    end

    hazard_match #(
        .REG_W (SB_REG_W),
        .DEPTH (DEPTH),
        .K_W   (FWD_W)
    ) u_match_a (
        .use_i      (id_rs_use),
        .src_i      (SB_REG_W'(id_rs)),
        .sb_valid_i (sb_valid),
        .sb_wreg_i  (sb_wreg),
        .sb_load_i  (sb_load),
        .hit_o      (hit_a),
        .k_o        (k_a),
        .is_load_o  (load_a)
    );

    hazard_match #(
        .REG_W (SB_REG_W),
        .DEPTH (DEPTH),
        .K_W   (FWD_W)
    ) u_match_b (
        .use_i      (id_rt_use),
        .src_i      (SB_REG_W'(id_rt)),
        .sb_valid_i (sb_valid),
        .sb_wreg_i  (sb_wreg),
        .sb_load_i  (sb_load),
        .hit_o      (hit_b),
        .k_o        (k_b),
        .is_load_o  (load_b)
    );

    // Stall/forward/flush decision; forward selects are zero while stalling.
    always_comb begin
        stall_a   = needs_stall(hit_a, load_a, k_a);
        stall_b   = needs_stall(hit_b, load_b, k_b);
        stall_int = id_valid && (stall_a || stall_b);
        fwd_a     = RF_K;
        fwd_b     = RF_K;
        if (!stall_int) begin
            if (hit_a && !stall_a) begin
                fwd_a = k_a;
            end
            if (hit_b && !stall_b) begin
                fwd_b = k_b;
            end
        end
        // A stalled branch still has unresolved operands, so it cannot squash.
        flush = id_valid && (id_branch_taken || id_jump) && !stall_int;
        stall = stall_int;
    end

    // Next scoreboard: shift one stage per cycle; a stall shifts in a bubble.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k];
        end
        if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].valid   = id_valid && id_wen && (id_wreg != '0) && !stall_int;
            sb_d[0].wreg    = SB_REG_W'(id_wreg);
            sb_d[0].is_load = id_is_load;
        end
    end

    // Next stall count: one per unfrozen stall cycle, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_int && !freeze && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule
